datapath_sequencer: RTL and testbench

//  Control-side counterpart of the RA/RB/RZ datapath: accepts one micro-command at a time over a

---
 rtl/datapath_sequencer.sv | 166 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Micro-command sequencer for the RA/RB/RZ datapath: accepts one command per valid/ready
// handshake and issues registered register-load and bus-drive strobes across T-states.
module datapath_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             busy,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_ADDA = 3'b010;
  localparam logic [2:0] OP_ADDB = 3'b011;
  localparam logic [2:0] OP_MOVA = 3'b100;
  localparam logic [2:0] OP_REPB = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Output vector layout: {cmd_ready, busy, RAin, RBin, RZin, RAout, RBout, RZout, done, err}
  localparam logic [9:0] OUT_IDLE = 10'b10_000_000_00;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       out_q, out_d;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_REPB);
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          cnt_d = cmd_count;
          case (cmd_op)
            OP_NOP: state_d = S_DONE;
            OP_LDA, OP_ADDA, OP_ADDB, OP_MOVA: state_d = S_T1;
            OP_REPB: begin
              if (cmd_count == CNT_ZERO) begin
                state_d = S_DONE;
              end else begin
                state_d = S_T1;
              end
            end
            default: state_d = S_DONE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T1: begin
        case (op_q)
          OP_ADDA, OP_ADDB, OP_REPB: state_d = S_T2;
          default:                   state_d = S_DONE;
        endcase
      end
      S_T2: begin
        // REPB loops back to T1 until the last pair has been issued
        if ((op_q == OP_REPB) && (cnt_q != CNT_ONE)) begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = S_T1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe
  always_comb begin
    out_d = 10'b00_000_000_00;
    case (state_d)
      S_IDLE: out_d[9] = 1'b1;
      S_T1: begin
        out_d[8] = 1'b1;
        case (op_d)
          OP_LDA: out_d[7] = 1'b1;
          OP_ADDA: begin
            out_d[5] = 1'b1;
            out_d[4] = 1'b1;
          end
          OP_ADDB, OP_REPB: begin
            out_d[5] = 1'b1;
            out_d[3] = 1'b1;
          end
          OP_MOVA: begin
            out_d[6] = 1'b1;
            out_d[4] = 1'b1;
          end
          default: out_d[7] = 1'b0;
        endcase
      end
      S_T2: begin
        out_d[8] = 1'b1;
        out_d[6] = 1'b1;
        out_d[2] = 1'b1;
      end
      S_DONE: begin
        out_d[8] = 1'b1;
        out_d[1] = 1'b1;
        out_d[0] = ~op_legal(op_d);
      end
      default: out_d[9] = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_q <= OUT_IDLE;
    end else begin
      out_q <= out_d;
    end
  end

  assign cmd_ready = out_q[9];
  assign busy      = out_q[8];
  assign RAin      = out_q[7];
  assign RBin      = out_q[6];
  assign RZin      = out_q[5];
  assign RAout     = out_q[4];
  assign RBout     = out_q[3];
  assign RZout     = out_q[2];
  assign done      = out_q[1];
  assign err       = out_q[0];

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: a queue of expected per-cycle output words built
// from the opcode table, plus a small RA/RB/RZ datapath model driven by the DUT strobes.
module tb_datapath_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_count = 4'd0;
  logic       cmd_ready, busy, RAin, RBin, RZin, RAout, RBout, RZout, done, err;

  int vectors = 0;
  int miscompares = 0;
  int dut_acc = 0;

  // {cmd_ready, busy, RAin, RBin, RZin, RAout, RBout, RZout, done, err}
  localparam logic [9:0] V_IDLE  = 10'b10_000_000_00;
  localparam logic [9:0] V_LDA   = 10'b01_100_000_00;
  localparam logic [9:0] V_ADDA1 = 10'b01_001_100_00;
  localparam logic [9:0] V_ADDB1 = 10'b01_001_010_00;
  localparam logic [9:0] V_ADD2  = 10'b01_010_001_00;
  localparam logic [9:0] V_MOVA  = 10'b01_010_100_00;
  localparam logic [9:0] V_DONE  = 10'b01_000_000_10;
  localparam logic [9:0] V_ERR   = 10'b01_000_000_11;

  logic [9:0] exp_q[$];

  logic [7:0] ra = 8'd0, rb = 8'd0, rz = 8'd0, imm = 8'd0, a_in = 8'd0;

  datapath_sequencer #(.CNT_W(4)) dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_ready(cmd_ready), .busy(busy),
    .RAin(RAin), .RBin(RBin), .RZin(RZin), .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Datapath model: bus carries the driven register, or the immediate when nothing drives it
  always @(posedge clock) begin
    logic [7:0] bus;
    bus = RAout ? ra : (RBout ? rb : (RZout ? rz : imm));
    if (RAin) ra <= bus;
    if (RBin) rb <= bus;
    if (RZin) rz <= a_in + bus;
  end

  function automatic logic [9:0] dut_vec();
    return {cmd_ready, busy, RAin, RBin, RZin, RAout, RBout, RZout, done, err};
  endfunction

  task automatic build(input logic [2:0] op, input logic [3:0] cnt);
    case (op)
      3'd0: exp_q.push_back(V_DONE);
      3'd1: begin exp_q.push_back(V_LDA); exp_q.push_back(V_DONE); end
      3'd2: begin exp_q.push_back(V_ADDA1); exp_q.push_back(V_ADD2); exp_q.push_back(V_DONE); end
      3'd3: begin exp_q.push_back(V_ADDB1); exp_q.push_back(V_ADD2); exp_q.push_back(V_DONE); end
      3'd4: begin exp_q.push_back(V_MOVA); exp_q.push_back(V_DONE); end
      3'd5: begin
        for (int i = 0; i < int'(cnt); i++) begin
          exp_q.push_back(V_ADDB1);
          exp_q.push_back(V_ADD2);
        end
        exp_q.push_back(V_DONE);
      end
      default: exp_q.push_back(V_ERR);
    endcase
  endtask

  task automatic check_outputs(input string tag);
    logic [9:0] got, expv;
    got  = dut_vec();
    expv = (exp_q.size() == 0) ? V_IDLE : exp_q[0];
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s outputs t=%0t got=%b expected=%b", tag, $time, got, expv);
    end
    vectors++;
    if ((({1'b0, got[4]} + {1'b0, got[3]} + {1'b0, got[2]}) > 2'd1) || ((got[7:5] & got[4:2]) != 3'b000)) begin
      miscompares++;
      $display("FAIL %s bus_invariant t=%0t got=%b expected no contention", tag, $time, got);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance the model across the next rising edge
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] cnt);
    check_outputs("cycle");
    if (v && cmd_ready) dut_acc++;
    cmd_valid = v;
    cmd_op    = op;
    cmd_count = cnt;
    if (exp_q.size() == 0) begin
      if (v) build(op, cnt);
    end else begin
      void'(exp_q.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
    step(1'b1, op, cnt);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, $urandom_range(0, 7), $urandom_range(0, 15));
  endtask

  initial begin
    @(negedge clock);
    check_outputs("in_reset");
    @(negedge clock);
    clear = 1'b1;
    step(1'b0, 3'd0, 4'd0);

    // LDA imm=5 then ADDA with A=3 -> RA=5, RB=8
    imm  = 8'd5;
    a_in = 8'd3;
    issue(3'd1, 4'd0);
    check_val("lda_ra", ra, 8'd5);
    issue(3'd2, 4'd0);
    check_val("adda_rb", rb, 8'd8);

    // RB=1 via LDA+MOVA, then REPB 3 with A=2 -> RB=7
    imm = 8'd1;
    issue(3'd1, 4'd0);
    issue(3'd4, 4'd0);
    check_val("mova_rb", rb, 8'd1);
    a_in = 8'd2;
    issue(3'd5, 4'd3);
    check_val("repb_rb", rb, 8'd7);

    issue(3'd5, 4'd0);
    issue(3'd0, 4'd0);
    issue(3'd7, 4'd0);
    issue(3'd6, 4'd0);
    issue(3'd5, 4'd15);
    step(1'b0, 3'd0, 4'd0);

    // Held-valid ADDB: one accept every 4 cycles
    dut_acc = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 3'd3, 4'd0);
    check_val("held_valid_accepts", dut_acc[7:0], 8'd5);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 3'd0, 4'd0);

    // Mid-sequence async clear
    step(1'b1, 3'd5, 4'd4);
    step(1'b0, 3'd0, 4'd0);
    #2;
    clear = 1'b0;
    #1;
    exp_q.delete();
    check_outputs("async_clear");
    @(negedge clock);
    check_outputs("held_clear");
    clear = 1'b1;
    step(1'b0, 3'd0, 4'd0);
    step(1'b0, 3'd0, 4'd0);

    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 15));
    end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 3'd0, 4'd0);
    check_outputs("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
